uart_frame_tx: RTL
==================

// Module: uart_frame_tx
// PURPOSE
//   Downstream consumer of the frame serializer's byte stream (dout/drdy pulses).
//   Buffers incoming bytes in a small FIFO and transmits each as a UART 8N1
//   character on txd, LSB first, toward the host/PC link.
//   Absorbs byte bursts and flags any byte lost to FIFO overflow.
// PARAMETERS
//   CLKS_PER_BIT  434  clk cycles per UART bit (50 MHz / 115200); legal >= 2
//   FIFO_AW       3    FIFO address width; depth = 2**FIFO_AW (8 bytes)
// PORTS
//   clk        in   1  system clock, all logic on rising edge
//   rst_n      in   1  asynchronous active-low reset
//   din        in   8  byte from upstream serializer
//   dvalid     in   1  one-cycle strobe: din valid this cycle
//   ovf_clr    in   1  synchronous clear of overflow flag
//   txd        out  1  UART serial line, idle high
//   busy       out  1  1 while FIFO non-empty or a character is on the line
//   fifo_full  out  1  FIFO holds 2**FIFO_AW bytes
//   overflow   out  1  sticky: a byte was dropped because FIFO was full
// BEHAVIOUR
//   Reset: reset rst_n, asynchronous, active-low; clock clk. On assertion:
//     txd=1, busy=0, fifo_full=0, overflow=0, FIFO flushed (count=0),
//     state=IDLE, baud/bit counters 0. Mid-character reset aborts it at once.
//   FIFO write: dvalid=1 and count<DEPTH at edge -> din stored, count+1.
//     dvalid=1 with count==DEPTH -> byte dropped, overflow<=1; a pop in the
//     same cycle does NOT make room (full is judged on pre-edge count).
//   Simultaneous push+pop (count not full): count unchanged, both performed.
//   overflow: set wins over ovf_clr in the same cycle; ovf_clr alone -> 0.
//   fifo_full = (count == DEPTH); busy = (state != IDLE) | (count != 0).
//   FSM (registered txd):
//     IDLE : txd=1. If count!=0: pop head into shift reg, txd<=0, -> START.
//     START: hold txd=0 for CLKS_PER_BIT cycles, then txd<=sh[0], -> DATA.
//     DATA : each bit held CLKS_PER_BIT cycles, shift right, 8 bits LSB first;
//            after bit 7 txd<=1, -> STOP.
//     STOP : hold txd=1 for CLKS_PER_BIT cycles, -> IDLE.
//   Latency: dvalid sampled at edge E0 into empty FIFO in IDLE -> pop and txd
//     falls at edge E1. Character = 10*CLKS_PER_BIT cycles; consecutive
//     characters separated by exactly 1 IDLE cycle (txd high).
//   Baud counter width $clog2(CLKS_PER_BIT), counts 0..CLKS_PER_BIT-1 and
//     wraps; bit index 3 bits. FIFO pointers FIFO_AW bits, wrap naturally;
//     count FIFO_AW+1 bits.
//   din/dvalid not required to be held; dvalid while transmitting is legal.
// TESTING (sim with CLKS_PER_BIT=4, FIFO_AW=3)
//   1 Reset: rst_n=0 -> txd=1, busy=0, fifo_full=0, overflow=0; no txd
//     activity for 100 cycles after release with dvalid=0.
//   2 Single byte 8'hCA -> txd low 1 cycle after write edge, then line
//     0,0,1,0,1,0,0,1,1,1 (start,data LSB first,stop), 4 cycles each; busy
//     drops 40 cycles after txd fell.
//   3 Frame CA 12 34 01 05 02 7F FE, dvalid on 8 consecutive cycles -> no
//     overflow, all 8 bytes decoded by bench UART RX in order, 1 idle cycle
//     between characters, busy=0 after 8*41-1 cycles.
//   4 Burst of 10 consecutive dvalid (bytes 0..9) -> byte 0 popped, bytes 1..8
//     stored, fifo_full=1, byte 9 dropped, overflow=1; RX sees bytes 0..8 only.
//   5 overflow=1, ovf_clr=1 with dvalid on full FIFO same cycle -> overflow
//     stays 1; next cycle ovf_clr=1 alone -> overflow=0.
//   6 Reset asserted mid-DATA with 3 bytes queued -> txd=1 immediately, busy=0;
//     after release no residual character is transmitted.

Source files
------------

// File: rtl/uart_frame_tx_if.sv
// uart_frame_tx_if
//   Byte stream from the frame serializer into the UART transmitter.
//   Signals:
//     din    [7:0]  byte from upstream serializer
//     dvalid        one-cycle strobe, din valid this cycle
//   Modports:
//     master  upstream side (drives din/dvalid)
//     slave   uart_frame_tx side (samples din/dvalid)
interface uart_frame_tx_if;
    logic [7:0] din;
    logic       dvalid;

    modport master (output din, output dvalid);
    modport slave  (input  din, input  dvalid);
endinterface

// File: rtl/uart_frame_tx.sv
// uart_frame_tx
//   Buffers bytes from the frame serializer in a small FIFO and sends each one
//   as a UART 8N1 character on txd, LSB first. Bytes arriving while the FIFO is
//   full are dropped and recorded in a sticky overflow flag.
//   Ports:
//     clk        system clock, rising edge
//     rst_n      asynchronous active-low reset
//     byte_in    slave side of uart_frame_tx_if (din, dvalid)
//     ovf_clr    synchronous clear of overflow
//     txd        UART serial line, idle high (registered)
//     busy       FIFO non-empty or a character on the line
//     fifo_full  FIFO holds 2**FIFO_AW bytes
//     overflow   sticky: a byte was dropped because the FIFO was full
module uart_frame_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_AW      = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    uart_frame_tx_if.slave  byte_in,
    input  logic            ovf_clr,
    output logic            txd,
    output logic            busy,
    output logic            fifo_full,
    output logic            overflow
);
    localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0]    BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [FIFO_AW:0] DEPTH     = {1'b1, {FIFO_AW{1'b0}}};

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               state, state_nx;
    logic [BW-1:0]        baud, baud_nx;
    logic [2:0]           bit_idx, bit_idx_nx;
    logic [7:0]           sh, sh_nx;
    logic                 txd_nx;

    logic [7:0]           mem [0:(1 << FIFO_AW) - 1];
    logic [FIFO_AW-1:0]   wr_ptr, rd_ptr;
    logic [FIFO_AW:0]     count;
    logic                 push, pop, drop;

    // Fullness is judged on the pre-edge count, so a pop in the same cycle
    // never makes room for an incoming byte.
    assign fifo_full = (count == DEPTH);
    assign push      = byte_in.dvalid && !fifo_full;
    assign drop      = byte_in.dvalid &&  fifo_full;
    assign pop       = (state == IDLE) && (count != '0);
    assign busy      = (state != IDLE) || (count != '0);

    // FIFO storage: data only, never reset
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= byte_in.din;
    end

    // FIFO control and overflow flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // a drop in the same cycle wins over the clear
            if (drop)
                overflow <= 1'b1;
            else if (ovf_clr)
                overflow <= 1'b0;
        end
    end

    // Transmitter state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            baud    <= '0;
            bit_idx <= '0;
            txd     <= 1'b1;
        end else begin
            state   <= state_nx;
            baud    <= baud_nx;
            bit_idx <= bit_idx_nx;
            txd     <= txd_nx;
        end
    end

    always_ff @(posedge clk) begin
        sh <= sh_nx;
    end

    // Transmitter next-state logic; txd_nx is the value the line takes next
    always_comb begin
        state_nx   = state;
        baud_nx    = baud;
        bit_idx_nx = bit_idx;
        sh_nx      = sh;
        txd_nx     = txd;
        case (state)
            IDLE: begin
                txd_nx     = 1'b1;
                baud_nx    = '0;
                bit_idx_nx = '0;
                if (pop) begin
                    sh_nx    = mem[rd_ptr];
                    txd_nx   = 1'b0;
                    state_nx = START;
                end
            end
            START: begin
                if (baud == BAUD_LAST) begin
                    baud_nx  = '0;
                    txd_nx   = sh[0];
                    state_nx = DATA;
                end else begin
                    baud_nx = baud + 1'b1;
                end
            end
            DATA: begin
                if (baud == BAUD_LAST) begin
                    baud_nx = '0;
                    if (bit_idx == 3'd7) begin
                        txd_nx   = 1'b1;
                        state_nx = STOP;
                    end else begin
                        // shift first, so the next bit to send is sh[1] now
                        sh_nx      = {1'b0, sh[7:1]};
                        txd_nx     = sh[1];
                        bit_idx_nx = bit_idx + 1'b1;
                    end
                end else begin
                    baud_nx = baud + 1'b1;
                end
            end
            STOP: begin
                if (baud == BAUD_LAST) begin
                    baud_nx  = '0;
                    state_nx = IDLE;
                end else begin
                    baud_nx = baud + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule
